// File: rtl/ir_fetch.sv
// ir_fetch: issues one instruction-memory read per PC value and holds the returned word in the IR until the decoder takes it.
// Optional performance counters are built only when IR_FETCH_PERF_EN is defined.
module ir_fetch #(
    parameter int unsigned                 data_size    = 32,
    parameter int unsigned                 address_size = 10,
    parameter logic [address_size-1:0]     im_start     = 'h80,
    parameter int unsigned                 cnt_size     = 32
) (
    input  logic                    local_clock,
    input  logic                    reset,
    input  logic [address_size-1:0] pc,
    input  logic                    flush,
    output logic                    im_req,
    output logic [address_size-1:0] im_addr,
    input  logic [data_size-1:0]    im_rdata,
    input  logic                    im_ack,
    output logic [data_size-1:0]    ir,
    output logic                    ir_valid,
    input  logic                    ir_ready,
    output logic                    ir_enable,
    output logic [cnt_size-1:0]     fetch_cnt,
    output logic [cnt_size-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        SETTLE
    } state_t;

    state_t                  state_q, state_d;
    logic [address_size-1:0] im_addr_q, im_addr_d;
    logic [data_size-1:0]    ir_q, ir_d;
    logic                    ir_valid_q, ir_valid_d;
    logic                    drop_q, drop_d;
    logic                    im_req_c, ir_enable_c;

    always_comb begin
        state_d     = state_q;
        im_addr_d   = im_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        drop_d      = drop_q;
        im_req_c    = 1'b0;
        ir_enable_c = 1'b0;
        case (state_q)
            IDLE: begin
                state_d   = REQ;
                im_addr_d = pc;
            end
            REQ: begin
                im_req_c = 1'b1;
                if (im_ack) begin
                    // A flush landing on the ack cycle poisons that word just like an earlier one.
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = SETTLE;
                    end else begin
                        ir_d       = im_rdata;
                        ir_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    state_d    = SETTLE;
                end else if (ir_ready) begin
                    ir_enable_c = 1'b1;
                    ir_valid_d  = 1'b0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                state_d   = REQ;
                im_addr_d = pc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge local_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            im_addr_q  <= im_start;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            im_addr_q  <= im_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            drop_q     <= drop_d;
        end
    end

    assign im_req    = im_req_c;
    assign im_addr   = im_addr_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign ir_enable = ir_enable_c;

`ifdef IR_FETCH_PERF_EN
    logic [cnt_size-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [cnt_size-1:0] stall_cnt_q, stall_cnt_d;
    logic                stall_c;

    always_comb begin
        stall_c     = ((state_q == REQ) && !im_ack) || ((state_q == HOLD) && !ir_ready);
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        // Both counters stick at all-ones rather than wrapping.
        if (ir_enable_c && (fetch_cnt_q != '1))
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        if (stall_c && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge local_clock) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ir_fetch.sv
// Directed per-cycle vectors for ir_fetch, followed by hand-written sequences for counters and reset.
module tb_ir_fetch;

`ifdef IR_FETCH_PERF_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic        local_clock = 1'b0;
    logic        reset;
    logic [9:0]  pc;
    logic        flush;
    logic        im_req;
    logic [9:0]  im_addr;
    logic [31:0] im_rdata;
    logic        im_ack;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        ir_enable;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    ir_fetch dut (
        .local_clock (local_clock),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .im_ack      (im_ack),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_enable   (ir_enable),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 local_clock = ~local_clock;

    typedef struct {
        logic        rst;
        logic [9:0]  pc;
        logic        fl;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [9:0]  addr;
        logic [31:0] ir;
        logic        vld;
        logic        en;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [9:0] p, input logic fl, input logic ack,
                                input logic [31:0] rd, input logic rdy, input logic req,
                                input logic [9:0] addr, input logic [31:0] irv, input logic vld,
                                input logic en);
        vec_t v;
        v.rst = rst; v.pc = p; v.fl = fl; v.ack = ack; v.rdata = rd; v.rdy = rdy;
        v.req = req; v.addr = addr; v.ir = irv; v.vld = vld; v.en = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let outputs settle.
    task automatic cyc(input logic rst, input logic [9:0] p, input logic fl, input logic ack,
                       input logic [31:0] rd, input logic rdy);
        @(negedge local_clock);
        reset = rst; pc = p; flush = fl; im_ack = ack; im_rdata = rd; ir_ready = rdy;
        #1;
    endtask

    initial begin
        reset = 1'b1; pc = 10'h80; flush = 1'b0; im_ack = 1'b0; im_rdata = '0; ir_ready = 1'b0;
        repeat (2) @(posedge local_clock);

        //              rst pc     fl ack rdata          rdy  req addr    ir             vld en
        tbl.push_back(mk(1, 10'h080, 0, 0, 32'h0,        0,   0, 10'h080, 32'h0,         0, 0));
        tbl.push_back(mk(0, 10'h080, 0, 1, 32'hA1,       1,   0, 10'h080, 32'h0,         0, 0));
        tbl.push_back(mk(0, 10'h080, 0, 1, 32'hA1,       1,   1, 10'h080, 32'h0,         0, 0));
        tbl.push_back(mk(0, 10'h080, 0, 1, 32'hA1,       1,   0, 10'h080, 32'hA1,        1, 1));
        tbl.push_back(mk(0, 10'h084, 0, 1, 32'hA2,       1,   0, 10'h080, 32'hA1,        0, 0));
        tbl.push_back(mk(0, 10'h084, 0, 1, 32'hA2,       1,   1, 10'h084, 32'hA1,        0, 0));
        tbl.push_back(mk(0, 10'h084, 0, 1, 32'hA2,       1,   0, 10'h084, 32'hA2,        1, 1));
        tbl.push_back(mk(0, 10'h088, 0, 1, 32'hA3,       1,   0, 10'h084, 32'hA2,        0, 0));
        tbl.push_back(mk(0, 10'h088, 0, 1, 32'hA3,       1,   1, 10'h088, 32'hA2,        0, 0));
        tbl.push_back(mk(0, 10'h088, 0, 1, 32'hA3,       1,   0, 10'h088, 32'hA3,        1, 1));
        // memory stall of 4 cycles
        tbl.push_back(mk(0, 10'h08C, 0, 0, 32'h0,        0,   0, 10'h088, 32'hA3,        0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 10'h08C, 0, 0, 32'hFFFFFFFF, 0, 1, 10'h08C, 32'hA3,     0, 0));
        tbl.push_back(mk(0, 10'h08C, 0, 1, 32'hB1,       0,   1, 10'h08C, 32'hA3,        0, 0));
        // decoder stall of 3 cycles
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 10'h08C, 0, 0, 32'h0,    0,   0, 10'h08C, 32'hB1,        1, 0));
        tbl.push_back(mk(0, 10'h08C, 0, 0, 32'h0,        1,   0, 10'h08C, 32'hB1,        1, 1));
        tbl.push_back(mk(0, 10'h090, 0, 0, 32'h0,        0,   0, 10'h08C, 32'hB1,        0, 0));
        // flush in REQ before ack, then redirected pc
        tbl.push_back(mk(0, 10'h090, 1, 0, 32'h0,        0,   1, 10'h090, 32'hB1,        0, 0));
        tbl.push_back(mk(0, 10'h200, 0, 0, 32'h0,        0,   1, 10'h090, 32'hB1,        0, 0));
        tbl.push_back(mk(0, 10'h200, 0, 1, 32'hDEADBEEF, 1,   1, 10'h090, 32'hB1,        0, 0));
        tbl.push_back(mk(0, 10'h200, 0, 0, 32'h0,        1,   0, 10'h090, 32'hB1,        0, 0));
        tbl.push_back(mk(0, 10'h200, 0, 1, 32'hC1,       0,   1, 10'h200, 32'hB1,        0, 0));
        // flush and ready together in HOLD
        tbl.push_back(mk(0, 10'h200, 1, 0, 32'h0,        1,   0, 10'h200, 32'hC1,        1, 0));
        tbl.push_back(mk(0, 10'h300, 0, 0, 32'h0,        0,   0, 10'h200, 32'hC1,        0, 0));
        // flush on the ack cycle
        tbl.push_back(mk(0, 10'h300, 1, 1, 32'hD1,       1,   1, 10'h300, 32'hC1,        0, 0));
        tbl.push_back(mk(0, 10'h304, 0, 0, 32'h0,        0,   0, 10'h300, 32'hC1,        0, 0));
        // reset mid-REQ
        tbl.push_back(mk(1, 10'h304, 0, 0, 32'h0,        0,   1, 10'h304, 32'hC1,        0, 0));
        tbl.push_back(mk(1, 10'h080, 0, 0, 32'h0,        0,   0, 10'h080, 32'h0,         0, 0));
        tbl.push_back(mk(0, 10'h080, 0, 0, 32'h0,        0,   0, 10'h080, 32'h0,         0, 0));
        tbl.push_back(mk(0, 10'h080, 0, 0, 32'h0,        0,   1, 10'h080, 32'h0,         0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].pc, tbl[i].fl, tbl[i].ack, tbl[i].rdata, tbl[i].rdy);
            chk($sformatf("v%0d im_req", i),    {31'b0, im_req},    {31'b0, tbl[i].req});
            chk($sformatf("v%0d im_addr", i),   {22'b0, im_addr},   {22'b0, tbl[i].addr});
            chk($sformatf("v%0d ir", i),        ir,                 tbl[i].ir);
            chk($sformatf("v%0d ir_valid", i),  {31'b0, ir_valid},  {31'b0, tbl[i].vld});
            chk($sformatf("v%0d ir_enable", i), {31'b0, ir_enable}, {31'b0, tbl[i].en});
        end

        // Counter sequence: fresh reset, 4-cycle memory stall, one delivery, one flushed HOLD.
        cyc(1, 10'h080, 0, 0, 32'h0, 0);
        cyc(0, 10'h080, 0, 0, 32'h0, 0);
        chk("rst fetch_cnt", fetch_cnt, 32'd0);
        chk("rst stall_cnt", stall_cnt, 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 10'h080, 0, 0, 32'h0, 0);
        chk("stall im_req held", {31'b0, im_req}, 32'd1);
        cyc(0, 10'h080, 0, 1, 32'h11111111, 0);
        cyc(0, 10'h080, 0, 0, 32'h0, 1);
        chk("stall_cnt after mem stall", stall_cnt, 32'(4 * P));
        chk("seq ir", ir, 32'h11111111);
        chk("seq ir_enable", {31'b0, ir_enable}, 32'd1);
        cyc(0, 10'h084, 0, 0, 32'h0, 0);
        chk("fetch_cnt after delivery", fetch_cnt, 32'(P));
        cyc(0, 10'h084, 0, 1, 32'h22222222, 0);
        cyc(0, 10'h084, 1, 0, 32'h0, 1);
        chk("flush+ready ir_enable", {31'b0, ir_enable}, 32'd0);
        cyc(0, 10'h088, 0, 0, 32'h0, 0);
        chk("flush+ready ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("flush+ready fetch_cnt", fetch_cnt, 32'(P));
        cyc(0, 10'h088, 0, 0, 32'h0, 0);
        cyc(1, 10'h088, 0, 0, 32'h0, 0);
        chk("pre-reset im_req", {31'b0, im_req}, 32'd1);
        cyc(0, 10'h088, 0, 0, 32'h0, 0);
        chk("mid-REQ reset im_req", {31'b0, im_req}, 32'd0);
        chk("mid-REQ reset im_addr", {22'b0, im_addr}, 32'h80);
        chk("mid-REQ reset fetch_cnt", fetch_cnt, 32'd0);
        chk("mid-REQ reset stall_cnt", stall_cnt, 32'd0);
        cyc(0, 10'h088, 0, 0, 32'h0, 0);
        chk("restart im_addr", {22'b0, im_addr}, 32'h88);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_fetch.md
# ir_fetch

Instruction-fetch stage sitting between instruction memory and the PC tick stage. Issues one read per PC value over a request/acknowledge memory handshake and holds the returned word in the IR until the decoder accepts it. Emits the single-cycle `ir_enable` pulse that advances the PC. Handles branch redirects (`flush`) without abandoning an outstanding memory transaction.

## Interface
- `data_size`, 32, instruction/memory word width
- `address_size`, 10, PC / instruction-memory byte-address width
- `im_start`, 'h80, reset value of `im_addr`; matches PC reset value
- `cnt_size`, 32, width of performance counters

- `local_clock`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `pc`  in  address_size  current PC from the PC tick stage
- `flush`  in  1  branch redirect; discard in-flight/held instruction
- `im_req`  out  1  memory read request
- `im_addr`  out  address_size  memory read address
- `im_rdata`  in  data_size  memory read data, valid when `im_ack`=1
- `im_ack`  in  1  memory acknowledge
- `ir`  out  data_size  instruction register
- `ir_valid`  out  1  `ir` holds a deliverable instruction
- `ir_ready`  in  1  decoder accepts `ir` this cycle
- `ir_enable`  out  1  one-cycle pulse on IR handoff; advances PC
- `fetch_cnt`  out  cnt_size  delivered-instruction count (see Configuration)
- `stall_cnt`  out  cnt_size  stall-cycle count (see Configuration)

## Operation
- States: IDLE, REQ, HOLD, SETTLE. Reset forces IDLE regardless of current state, including mid-transaction.
- IDLE: all outputs inactive. Moves to REQ on the next cycle. `im_addr` is loaded from `pc` on this transition.
- REQ: `im_req`=1 and `im_addr` stable until the handshake completes (`im_req`&`im_ack`); `im_ack` in the first REQ cycle is legal.
  - On handshake with drop flag clear: `ir`<=`im_rdata`, `ir_valid`<=1, go to HOLD.
  - On handshake with drop flag set: discard data, clear drop flag, go to SETTLE. `ir` is unchanged.
- `flush` in REQ sets the drop flag. The request is never withdrawn; `im_req` stays high until ack.
- `flush` coinciding with the ack cycle discards that data.
- HOLD: `ir_valid`=1, `ir` stable.
  - On `ir_ready`=1 and `flush`=0: `ir_enable` pulses for that same cycle, `ir_valid`<=0, go to SETTLE.
  - On `flush`=1: `ir_valid`<=0, no `ir_enable`, go to SETTLE. `flush` wins over `ir_ready`.
- SETTLE: one cycle so the PC tick stage can present the updated `pc`. Then go to REQ, with `im_addr`<=`pc` sampled at the end of SETTLE.
- `ir_enable` is combinational from state HOLD & `ir_ready` & !`flush`. It is never high outside HOLD and is never high for two consecutive cycles.
- `im_addr` is the raw byte address; no alignment check, no wrap handling beyond address_size truncation.

## Timing
- Reset values: `im_req`=0, `im_addr`=im_start, `ir`=0, `ir_valid`=0, `ir_enable`=0, `fetch_cnt`=0, `stall_cnt`=0, drop flag=0, state=IDLE.
- First request: `im_req` rises in the 2nd cycle after `reset` deasserts (IDLE, then REQ).
- Ack to `ir_valid`: 1 cycle (registered).
- Minimum throughput: 3 cycles per instruction (REQ with immediate ack, HOLD with immediate ready, SETTLE).
- Memory stall of N cycles adds N cycles. Decoder stall of M cycles adds M cycles.
- Flush latency: `ir_valid` low on the cycle after `flush`. The next valid request uses the `pc` present at the end of SETTLE.

## Configuration
- `IR_FETCH_PERF_EN` defined:
  - `fetch_cnt` increments on every `ir_enable` pulse.
  - `stall_cnt` increments on every cycle in REQ without `im_ack` and every cycle in HOLD without `ir_ready`.
  - Both counters saturate at all-ones and clear on `reset`.
- `IR_FETCH_PERF_EN` undefined: counter logic is absent; both ports are present and tied to 0.

## Test plan
- Reset, then `im_ack` and `ir_ready` tied 1, `pc`=0x80, 0x84, 0x88 → `im_addr` 0x80, 0x84, 0x88 every 3 cycles; `ir_enable` pulses at cycles 3, 6, 9.
- `im_ack` delayed 4 cycles → `im_req` and `im_addr` held steady for 5 cycles, `ir_valid` one cycle after ack, `stall_cnt`=4 (macro on).
- `ir_ready` low 3 cycles in HOLD → `ir` stable, `ir_valid`=1 throughout, single `ir_enable` pulse on the ready cycle.
- `flush` pulsed in REQ before ack, data 0xDEADBEEF → `ir` unchanged, no `ir_valid`, no `ir_enable`, new request to the redirected `pc` after SETTLE.
- `flush` and `ir_ready` both high in HOLD → no `ir_enable`, `fetch_cnt` unchanged, `ir_valid` 0 next cycle.
- `reset` asserted mid-REQ → next cycle `im_req`=0, `im_addr`=0x80, counters 0, state IDLE.
